// File: rtl/amplitude_readout_pkg.sv
// Shared quantum-emulator definitions: default sizing and the readout FSM encoding.
package amplitude_readout_pkg;

   localparam int unsigned NUM_QUBIT_DEF   = 3;
   localparam int unsigned COMPLEX_BIT_DEF = 24;
   localparam int unsigned FP_BIT_DEF      = 22;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } readout_state_e;

endpackage

// File: rtl/amplitude_skid_fifo.sv
// Two-entry buffer built as a head register plus a skid (tail) register.
// The head is what the stream presents, so it only changes on a pop or while empty.
module amplitude_skid_fifo
   import amplitude_readout_pkg::*;
#(
   parameter int unsigned data_w = 51
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic [data_w-1:0] i_push_data,
   input  logic              i_pop,
   output logic              o_head_valid,
   output logic              o_tail_valid,
   output logic [data_w-1:0] o_head_data
);

   logic              r_head_valid;
   logic              r_tail_valid;
   logic [data_w-1:0] r_head_data;
   logic [data_w-1:0] r_tail_data;
   logic              w_pop;

   assign w_pop        = i_pop & r_head_valid;
   assign o_head_valid = r_head_valid;
   assign o_tail_valid = r_tail_valid;
   assign o_head_data  = r_head_data;

   // Advance the tail into the head on a pop; new data fills the first free slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head_valid <= 1'b0;
         r_tail_valid <= 1'b0;
         r_head_data  <= {data_w{1'b0}};
         r_tail_data  <= {data_w{1'b0}};
      end else if (w_pop) begin
         if (r_tail_valid) begin
            r_head_data  <= r_tail_data;
            r_head_valid <= 1'b1;
            r_tail_valid <= i_push;
            if (i_push) begin
               r_tail_data <= i_push_data;
            end
         end else begin
            r_head_valid <= i_push;
            if (i_push) begin
               r_head_data <= i_push_data;
            end
         end
      end else if (!r_head_valid) begin
         r_head_valid <= i_push;
         if (i_push) begin
            r_head_data <= i_push_data;
         end
      end else if (i_push) begin
         r_tail_valid <= 1'b1;
         r_tail_data  <= i_push_data;
      end
   end

endmodule

// File: rtl/amplitude_readout.sv
// Sweeps the amplitude RAM from address 0 upward and streams each amplitude with its
// basis-state index, optionally suppressing zero amplitudes, and counts nonzero ones.
module amplitude_readout
   import amplitude_readout_pkg::*;
#(
   parameter int unsigned num_qubit   = NUM_QUBIT_DEF,
   parameter int unsigned complex_bit = COMPLEX_BIT_DEF,
   parameter int unsigned fp_bit      = FP_BIT_DEF
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     skip_zero,
   input  logic                     ram_write_busy,
   output logic                     rd_enable,
   output logic [num_qubit-1:0]     rd_address,
   input  logic [2*complex_bit-1:0] read_amplitude,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2*complex_bit-1:0] out_amplitude,
   output logic [num_qubit-1:0]     out_address,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done,
   output logic [num_qubit:0]       nonzero_count
);

   localparam int unsigned AMP_W   = 2 * complex_bit;
   localparam int unsigned ENTRY_W = AMP_W + num_qubit;
   localparam int unsigned INT_W   = complex_bit - fp_bit;
   localparam logic [num_qubit:0] ADDR_LAST = {1'b0, {num_qubit{1'b1}}};
   localparam logic [num_qubit:0] ONE_CNT   = {{num_qubit{1'b0}}, 1'b1};

   readout_state_e       r_state;
   logic [num_qubit:0]   r_addr;
   logic                 r_inflight;
   logic                 r_inflight_last;
   logic [num_qubit-1:0] r_inflight_addr;
   logic                 r_skip;
   logic                 r_final_seen;
   logic                 r_busy;
   logic                 r_done;
   logic [num_qubit:0]   r_nonzero;

   logic                 w_amp_zero;
   logic                 w_push;
   logic                 w_release;
   logic                 w_pop;
   logic [2:0]           w_occ;
   logic                 w_issue;
   logic                 w_head_valid;
   logic                 w_tail_valid;
   logic [ENTRY_W-1:0]   w_head_data;
   logic [complex_bit-1:0] w_re;
   logic [complex_bit-1:0] w_im;

   assign w_re = read_amplitude[AMP_W-1:complex_bit];
   assign w_im = read_amplitude[complex_bit-1:0];

   // Issue/flow control. An entry may be withheld in skip mode until it is known
   // whether a later survivor follows, so out_last can land on the true final beat.
   // Credit counts the entry popped this cycle, which is what lets a 2-entry buffer
   // keep up with one beat per cycle.
   always_comb begin
      w_amp_zero = ((w_re[complex_bit-1:fp_bit] == {INT_W{1'b0}}) &&
                    (w_re[fp_bit-1:0]           == {fp_bit{1'b0}}) &&
                    (w_im[complex_bit-1:fp_bit] == {INT_W{1'b0}}) &&
                    (w_im[fp_bit-1:0]           == {fp_bit{1'b0}}));
      w_push    = r_inflight & ~(r_skip & w_amp_zero);
      w_release = w_head_valid & (w_tail_valid | ~r_skip | r_final_seen);
      w_pop     = w_release & out_ready;
      w_occ     = {2'b00, w_head_valid} + {2'b00, w_tail_valid}
                + {2'b00, r_inflight}   - {2'b00, w_pop};
      if ((r_state == ST_READ) && !ram_write_busy && (w_occ < 3'd2)) begin
         w_issue = 1'b1;
      end else begin
         w_issue = 1'b0;
      end
   end

   amplitude_skid_fifo #(
      .data_w (ENTRY_W)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .i_push       (w_push),
      .i_push_data  ({r_inflight_addr, read_amplitude}),
      .i_pop        (w_pop),
      .o_head_valid (w_head_valid),
      .o_tail_valid (w_tail_valid),
      .o_head_data  (w_head_data)
   );

   assign rd_enable     = w_issue;
   assign rd_address    = r_addr[num_qubit-1:0];
   assign out_valid     = w_release;
   assign out_amplitude = w_head_data[AMP_W-1:0];
   assign out_address   = w_head_data[ENTRY_W-1:AMP_W];
   assign out_last      = w_head_valid & r_final_seen & ~w_tail_valid;
   assign busy          = r_busy;
   assign done          = r_done;
   assign nonzero_count = r_nonzero;

   // Sweep FSM: address counter, sweep-mode capture, and registered busy/done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_addr       <= {(num_qubit+1){1'b0}};
         r_skip       <= 1'b0;
         r_final_seen <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state      <= ST_READ;
                  r_addr       <= {(num_qubit+1){1'b0}};
                  r_skip       <= skip_zero;
                  r_final_seen <= 1'b0;
                  r_busy       <= 1'b1;
               end else begin
                  r_busy <= 1'b0;
               end
            end
            ST_READ: begin
               if (w_issue) begin
                  r_addr <= r_addr + ONE_CNT;
                  if (r_addr == ADDR_LAST) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (r_inflight && r_inflight_last) begin
                  r_final_seen <= 1'b1;
               end
               if (r_final_seen && !w_head_valid) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Track the single read in flight and count nonzero amplitudes as they return.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_inflight_addr <= {num_qubit{1'b0}};
         r_nonzero       <= {(num_qubit+1){1'b0}};
      end else begin
         r_inflight      <= w_issue;
         r_inflight_last <= (r_addr == ADDR_LAST);
         r_inflight_addr <= r_addr[num_qubit-1:0];
         if ((r_state == ST_IDLE) && start) begin
            r_nonzero <= {(num_qubit+1){1'b0}};
         end else if (r_inflight && !w_amp_zero) begin
            r_nonzero <= r_nonzero + ONE_CNT;
         end
      end
   end

endmodule

// File: tb/tb_amplitude_readout.sv
// Directed bench for amplitude_readout with a behavioural 1-cycle-latency amplitude RAM.
module tb_amplitude_readout;

   localparam int NQ    = 3;
   localparam int CB    = 24;
   localparam int AW    = 2 * CB;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          skip_zero;
   logic          ram_write_busy;
   logic          rd_enable;
   logic [NQ-1:0] rd_address;
   logic [AW-1:0] read_amplitude = {AW{1'b0}};
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_amplitude;
   logic [NQ-1:0] out_address;
   logic          out_last;
   logic          busy;
   logic          done;
   logic [NQ:0]   nonzero_count;

   logic [AW-1:0] amp_mem [DEPTH];

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   logic [NQ-1:0] beat_addr [$];
   logic [AW-1:0] beat_data [$];
   logic          beat_last [$];
   int            beat_cyc  [$];
   logic [NQ-1:0] issue_addr [$];
   int            busy_issue;
   int            stall_err;
   int            done_cnt;

   amplitude_readout dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .skip_zero      (skip_zero),
      .ram_write_busy (ram_write_busy),
      .rd_enable      (rd_enable),
      .rd_address     (rd_address),
      .read_amplitude (read_amplitude),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_amplitude  (out_amplitude),
      .out_address    (out_address),
      .out_last       (out_last),
      .busy           (busy),
      .done           (done),
      .nonzero_count  (nonzero_count)
   );

   always #5 clk = ~clk;

   // RAM model: data appears the cycle after rd_enable.
   always @(posedge clk) begin
      if (rd_enable) read_amplitude <= amp_mem[rd_address];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_rd_enable"}, 64'(rd_enable), 64'd0);
      check({tag, "_rd_address"}, 64'(rd_address), 64'd0);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_out_amplitude"}, 64'(out_amplitude), 64'd0);
      check({tag, "_out_address"}, 64'(out_address), 64'd0);
      check({tag, "_out_last"}, 64'(out_last), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_nonzero"}, 64'(nonzero_count), 64'd0);
   endtask

   // One sweep, driven and observed cycle by cycle on the falling edge (+1).
   task automatic sweep(input logic skip, input int ready_mode, input int busy_at,
                        input int busy_len, input int restart_at);
      logic          stalled_prev;
      logic [AW-1:0] hold_amp;
      logic [NQ-1:0] hold_addr;
      logic          hold_last;
      int            post;
      beat_addr.delete(); beat_data.delete(); beat_last.delete();
      beat_cyc.delete();  issue_addr.delete();
      busy_issue = 0; stall_err = 0; done_cnt = 0; post = 0;
      stalled_prev = 1'b0; hold_amp = '0; hold_addr = '0; hold_last = 1'b0;
      @(negedge clk);
      skip_zero = skip; start = 1'b1; out_ready = 1'b1; ram_write_busy = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 300; k++) begin
         out_ready      = (ready_mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
         ram_write_busy = (k >= busy_at) && (k < busy_at + busy_len);
         start          = (k == restart_at);
         #1;
         if (rd_enable) begin
            issue_addr.push_back(rd_address);
            if (ram_write_busy) busy_issue++;
         end
         if (stalled_prev && (out_valid !== 1'b1 || out_amplitude !== hold_amp ||
                              out_address !== hold_addr || out_last !== hold_last))
            stall_err++;
         stalled_prev = out_valid && !out_ready;
         hold_amp = out_amplitude; hold_addr = out_address; hold_last = out_last;
         if (out_valid && out_ready) begin
            beat_addr.push_back(out_address);
            beat_data.push_back(out_amplitude);
            beat_last.push_back(out_last);
            beat_cyc.push_back(k);
         end
         if (done) done_cnt++;
         if (done_cnt > 0) post++;
         @(negedge clk);
         if (post > 4) break;
      end
      start = 1'b0; out_ready = 1'b1; ram_write_busy = 1'b0;
   endtask

   task automatic verify_full(input string tag);
      check({tag, "_beats"}, 64'(beat_addr.size()), 64'd8);
      for (int i = 0; i < beat_addr.size() && i < 8; i++) begin
         check({tag, "_addr"}, 64'(beat_addr[i]), 64'(i));
         check({tag, "_data"}, 64'(beat_data[i]), 64'(amp_mem[i]));
         check({tag, "_last"}, 64'(beat_last[i]), 64'(i == 7));
      end
      check({tag, "_done"}, 64'(done_cnt), 64'd1);
      check({tag, "_stall"}, 64'(stall_err), 64'd0);
   endtask

   initial begin
      int found;
      int extra_done;
      int extra_valid;
      rst = 1'b1; start = 1'b0; skip_zero = 1'b0; ram_write_busy = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) amp_mem[i] = {AW{1'b0}};
      repeat (3) @(negedge clk);
      check_idle_zero("reset");
      rst = 1'b0;

      // Single unit amplitude at address 0, full stream; a stray start mid-sweep is ignored.
      amp_mem[0] = 48'h4000_0000_0000;
      sweep(1'b0, 0, 1000, 0, 5);
      verify_full("one_hot");
      check("one_hot_nonzero", 64'(nonzero_count), 64'd1);
      if (beat_cyc.size() == 8) check("one_hot_rate", 64'(beat_cyc[7] - beat_cyc[0]), 64'd7);
      check("one_hot_idle", 64'(busy), 64'd0);

      // Same preload with zero suppression: a single beat that carries out_last.
      sweep(1'b1, 0, 1000, 0, -1);
      check("skip_beats", 64'(beat_addr.size()), 64'd1);
      if (beat_addr.size() == 1) begin
         check("skip_addr", 64'(beat_addr[0]), 64'd0);
         check("skip_data", 64'(beat_data[0]), 64'h4000_0000_0000);
         check("skip_last", 64'(beat_last[0]), 64'd1);
      end
      check("skip_done", 64'(done_cnt), 64'd1);
      check("skip_nonzero", 64'(nonzero_count), 64'd1);

      // All nonzero with out_ready toggling 1-0-0-1.
      for (int i = 0; i < DEPTH; i++)
         amp_mem[i] = {8'(i + 1), 16'h0000, 16'h0000, 8'(8'hA0 + i)};
      sweep(1'b0, 1, 1000, 0, -1);
      verify_full("stall");
      check("stall_nonzero", 64'(nonzero_count), 64'd8);

      // RAM write activity for 5 cycles mid-sweep.
      sweep(1'b0, 0, 3, 5, -1);
      verify_full("wbusy");
      check("wbusy_issue_while_busy", 64'(busy_issue), 64'd0);
      check("wbusy_issues", 64'(issue_addr.size()), 64'd8);
      for (int i = 0; i < issue_addr.size() && i < 8; i++)
         check("wbusy_issue_order", 64'(issue_addr[i]), 64'(i));

      // Reset at the read of address 3.
      found = 0;
      @(negedge clk);
      skip_zero = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 50; k++) begin
         #1;
         if (rd_enable && rd_address == 3'd3) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      check("rst_reached_addr3", 64'(found), 64'd1);
      rst = 1'b1;
      #1;
      check_idle_zero("rst_mid");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      extra_done = 0; extra_valid = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) extra_done++;
         if (out_valid) extra_valid++;
      end
      check("rst_no_done", 64'(extra_done), 64'd0);
      check("rst_no_beats", 64'(extra_valid), 64'd0);
      sweep(1'b0, 0, 1000, 0, -1);
      verify_full("after_rst");

      // Everything zero with suppression: no beats, still done.
      for (int i = 0; i < DEPTH; i++) amp_mem[i] = {AW{1'b0}};
      sweep(1'b1, 0, 1000, 0, -1);
      check("zero_beats", 64'(beat_addr.size()), 64'd0);
      check("zero_done", 64'(done_cnt), 64'd1);
      check("zero_nonzero", 64'(nonzero_count), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/amplitude_readout.md
AMPLITUDE_READOUT -- requirements
Module: amplitude_readout

Interface
REQ-001 SHALL have parameter num_qubit, default 3, meaning address width; the amplitude memory depth is 2**num_qubit.
REQ-002 SHALL have parameter complex_bit, default 24, meaning width of each real/imag half.
REQ-003 SHALL have parameter fp_bit, default 22, meaning fractional bits per half.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port start  input  1  pulse that begins one sweep; ignored unless IDLE.
REQ-007 SHALL have port skip_zero  input  1  sampled at start; 1 = suppress amplitudes equal to zero.
REQ-008 SHALL have port ram_write_busy  input  1  amplitude-RAM write-enable OR; blocks read issue.
REQ-009 SHALL have port rd_enable  output  1  read request to the amplitude controller read port.
REQ-010 SHALL have port rd_address  output  num_qubit  read address.
REQ-011 SHALL have port read_amplitude  input  2*complex_bit  RAM data, valid exactly 1 cycle after rd_enable; real in [2*complex_bit-1:complex_bit], imag in [complex_bit-1:0].
REQ-012 SHALL have port out_valid  output  1  stream data valid.
REQ-013 SHALL have port out_ready  input  1  downstream accept.
REQ-014 SHALL have port out_amplitude  output  2*complex_bit  amplitude.
REQ-015 SHALL have port out_address  output  num_qubit  basis-state index of out_amplitude.
REQ-016 SHALL have port out_last  output  1  marks final beat of a sweep.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse when the sweep completes.
REQ-019 SHALL have port nonzero_count  output  num_qubit+1  count of nonzero amplitudes in the last sweep.

Function
REQ-020 SHALL implement FSM IDLE -> READ (on start) -> DRAIN (after last read issued) -> DONE (buffer empty, last beat accepted) -> IDLE (next cycle).
REQ-021 SHALL, in READ, issue rd_enable for address 0 through 2**num_qubit-1, ascending, at most one per cycle.
REQ-022 SHALL issue a read only when ram_write_busy=0 and (buffer occupancy + reads in flight) < 2.
REQ-023 SHALL capture read_amplitude together with its address one cycle after each rd_enable into a 2-entry FIFO.
REQ-024 SHALL, with skip_zero=1, drop captured entries whose real and imag halves are both zero, without writing them to the FIFO.
REQ-025 SHALL present the FIFO head on out_* with out_valid; pop occurs when out_valid & out_ready.
REQ-026 SHALL assert out_last on the beat carrying address 2**num_qubit-1; if that entry is dropped, SHALL assert it on the last surviving beat; if all entries are dropped, SHALL emit no beats and still pulse done.
REQ-027 SHALL keep out_amplitude/out_address/out_last stable while out_valid=1 and out_ready=0.
REQ-028 SHALL increment nonzero_count for each nonzero amplitude regardless of skip_zero; clear it on start; hold it after done.
REQ-029 SHALL wrap rd_address only at sweep end; the address counter is num_qubit+1 bits wide to detect completion.
REQ-030 SHALL ignore start while busy=1; start and done in the same cycle SHALL be ignored.
REQ-031 SHALL sustain one beat per cycle when out_ready=1 and ram_write_busy=0.

Reset
REQ-032 SHALL, on rst, force state IDLE, FIFO empty, in-flight flag 0, rd_enable=0, rd_address=0, out_valid=0, out_amplitude=0, out_address=0, out_last=0, busy=0, done=0, nonzero_count=0.
REQ-033 SHALL abandon any sweep in progress on rst mid-operation with no further beats or done pulse.

Structure
REQ-034 SHALL take num_qubit/complex_bit/fp_bit defaults and the FSM state encoding from the shared quantum-emulator package.
REQ-035 SHALL implement the 2-entry buffer as sub-module amplitude_skid_fifo.

Verification
REQ-036 SHALL check: ram preloaded with amp[0]=1.0 (bit 46 set), others zero, skip_zero=0, out_ready=1 -> 8 beats addresses 0..7, last on 7, done, nonzero_count=1.
REQ-037 SHALL check: same preload with skip_zero=1 -> exactly one beat, address 0, out_last=1, nonzero_count=1.
REQ-038 SHALL check: all 8 amplitudes nonzero, out_ready toggling 1-0-0-1 -> 8 beats in order, no loss or duplication, data stable while stalled.
REQ-039 SHALL check: ram_write_busy held high 5 cycles mid-sweep -> no rd_enable during those cycles, sweep resumes at the next address.
REQ-040 SHALL check: rst asserted at address 3 -> all outputs zero immediately, no done; a following start gives a full sweep from address 0.
REQ-041 SHALL check: all amplitudes zero with skip_zero=1 -> no beats, done pulse, nonzero_count=0.
